msrv32_instr_fetch_queue: RTL and testbench

//   Front-end fetch unit for the msrv32 core: walks the PC and issues one-outstanding requests to instruction memory.

---
 rtl/msrv32_fetch_pkg.sv | 22 ++
 rtl/msrv32_fetch_fifo.sv | 57 +++++
 rtl/msrv32_instr_fetch_queue.sv | 177 +++++++++++++++++
 tb/tb_msrv32_instr_fetch_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_fetch_pkg.sv
// Shared types and constants for the msrv32 instruction fetch queue.
package msrv32_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction memory is word addressed; the low two bits are always zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/clear and an occupancy count.
// clear wins over push and pop in the same cycle.
module msrv32_fetch_fifo
  import msrv32_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on every accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/msrv32_instr_fetch_queue.sv
// msrv32 front-end fetch unit: one outstanding imem request, DEPTH-entry
// instruction queue towards decode, redirect handling with response squash.
// Optional build macro: MSRV32_FETCH_PERF_EN adds fetch/squash event counters.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   FETCH  | no request outstanding; issue one when the queue has room
//   WAIT   | request at imem_addr_out outstanding; its data will be pushed
//   SQUASH | request outstanding but a redirect happened; drop its data
module msrv32_instr_fetch_queue
  import msrv32_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
`ifdef MSRV32_FETCH_PERF_EN
  output logic [31:0] fetch_count_out,
  output logic [31:0] squash_count_out,
`endif
  output logic        flush_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic         clk;
  logic         rst_n;
  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  req_addr, req_addr_next;
  logic [31:0]  redir_pc;
  logic [31:0]  fetch_pc_inc;
  logic         push;
  logic         pop;
  logic         discard;
  logic [CW-1:0] q_count;
  logic [CW-1:0] count_after;
  logic          room_now;
  logic          room_after;
  logic          q_empty;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;

  assign clk   = ms_riscv32_mp_clk_in;
  assign rst_n = ms_riscv32_mp_rst_n_in;

  assign redir_pc     = word_align(redirect_pc_in);
  assign fetch_pc_inc = fetch_pc + 32'd4;

  // Only a non-redirected ack in WAIT produces a queue entry.
  assign push    = (state == WAIT) & imem_ack_in & ~redirect_in;
  assign pop     = instr_valid_out & instr_ready_in;
  assign discard = imem_ack_in & ((state == SQUASH) | ((state == WAIT) & redirect_in));

  // count_after is only consulted on a non-redirect ack in WAIT, where the
  // queue holds at most DEPTH-1 entries, so it cannot exceed DEPTH.
  assign count_after = q_count + CW'(push) - CW'(pop);
  assign room_now    = (q_count < CW'(DEPTH));
  assign room_after  = (count_after < CW'(DEPTH));

  assign q_din.pc    = fetch_pc;
  assign q_din.instr = imem_rdata_in;

  msrv32_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (redirect_in),
    .din   (q_din),
    .dout  (q_head),
    .count (q_count),
    .empty (q_empty)
  );

  // State, next fetch address and held request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      fetch_pc <= word_align(RESET_PC);
      req_addr <= word_align(RESET_PC);
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

  // Next-state logic; a redirect overrides every other decision.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    unique case (state)
      FETCH: begin
        if (redirect_in) begin
          // The queue is cleared at this edge, so there is always room.
          fetch_pc_next = redir_pc;
          req_addr_next = redir_pc;
          state_next    = WAIT;
        end else if (room_now) begin
          req_addr_next = fetch_pc;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_in) begin
          fetch_pc_next = redir_pc;
          if (imem_ack_in) begin
            req_addr_next = redir_pc;
            state_next    = WAIT;
          end else begin
            // Keep req/addr stable until the old request completes.
            state_next    = SQUASH;
          end
        end else if (imem_ack_in) begin
          fetch_pc_next = fetch_pc_inc;
          if (room_after) begin
            req_addr_next = fetch_pc_inc;
            state_next    = WAIT;
          end else begin
            state_next    = FETCH;
          end
        end
      end
      SQUASH: begin
        if (redirect_in) begin
          fetch_pc_next = redir_pc;
        end
        if (imem_ack_in) begin
          req_addr_next = redirect_in ? redir_pc : fetch_pc;
          state_next    = WAIT;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign imem_req_out    = (state != FETCH);
  assign imem_addr_out   = req_addr;
  assign instr_valid_out = ~q_empty;
  assign flush_out       = q_empty;
  assign instr_out       = q_empty ? NOP_INSTR : q_head.instr;
  assign pc_out          = q_empty ? 32'h0 : q_head.pc;

`ifdef MSRV32_FETCH_PERF_EN
  // Event counters: instructions queued and responses thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_out  <= '0;
      squash_count_out <= '0;
    end else begin
      if (push)    fetch_count_out  <= fetch_count_out + 32'd1;
      if (discard) squash_count_out <= squash_count_out + 32'd1;
    end
  end
`else
  logic discard_unused;
  assign discard_unused = discard;
`endif

endmodule

// File: tb/tb_msrv32_instr_fetch_queue.sv
// Directed self-checking bench for msrv32_instr_fetch_queue (DEPTH=2, RESET_PC=0).
module tb_msrv32_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
`ifdef MSRV32_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  msrv32_instr_fetch_queue #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .imem_req_out           (imem_req),
    .imem_addr_out          (imem_addr),
    .imem_ack_in            (imem_ack),
    .imem_rdata_in          (imem_rdata),
    .redirect_in            (redirect),
    .redirect_pc_in         (redirect_pc),
    .instr_valid_out        (instr_valid),
    .instr_ready_in         (instr_ready),
    .instr_out              (instr),
    .pc_out                 (pc),
`ifdef MSRV32_FETCH_PERF_EN
    .fetch_count_out        (fetch_count),
    .squash_count_out       (squash_count),
`endif
    .flush_out              (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, imem_req},    32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_flush"}, {31'h0, flush},       32'h1);
    check({tag, "_instr"}, instr,                32'h0000_0013);
    check({tag, "_pc"},    pc,                   32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    idle_inputs();
    tick();
    tick();
    check_reset_outputs("rst");

    // Test 1: first request in cycle 1 after release.
    rst_n = 1'b1;
    tick();
    check("t1_req",   {31'h0, imem_req},    32'h1);
    check("t1_addr",  imem_addr,            32'h0);
    check("t1_valid", {31'h0, instr_valid}, 32'h0);
    check("t1_flush", {31'h0, flush},       32'h1);
    check("t1_instr", instr,                32'h0000_0013);

    // Test 2: ack every cycle, decode always ready.
    instr_ready = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h0010_0093;
    tick();
    check("t2_valid0", {31'h0, instr_valid}, 32'h1);
    check("t2_pc0",    pc,                   32'h0);
    check("t2_instr0", instr,                32'h0010_0093);
    check("t2_addr4",  imem_addr,            32'h4);
    imem_rdata = 32'h0020_0113;
    tick();
    check("t2_pc1",    pc,                   32'h4);
    check("t2_instr1", instr,                32'h0020_0113);
    check("t2_addr8",  imem_addr,            32'h8);
    imem_rdata = 32'h0030_0193;
    tick();
    check("t2_pc2",    pc,                   32'h8);
    check("t2_instr2", instr,                32'h0030_0193);
    check("t2_addrC",  imem_addr,            32'hC);
    check("t2_req",    {31'h0, imem_req},    32'h1);
    idle_inputs();
    tick();
    check("t2_drained", {31'h0, instr_valid}, 32'h0);
    check("t2_flush",   {31'h0, flush},       32'h1);

    // Test 3: back-pressure fills the two-entry queue.
    instr_ready = 1'b0;
    do_reset();
    tick();
    check("t3_addr0", imem_addr, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0010_0093;
    tick();
    check("t3_addr4",  imem_addr,            32'h4);
    check("t3_valid1", {31'h0, instr_valid}, 32'h1);
    imem_rdata = 32'h0020_0113;
    tick();
    check("t3_req_drop", {31'h0, imem_req},    32'h0);
    check("t3_valid2",   {31'h0, instr_valid}, 32'h1);
    check("t3_pc_head",  pc,                   32'h0);
    check("t3_instr_hd", instr,                32'h0010_0093);
    idle_inputs();
    tick();
    check("t3_req_hold", {31'h0, imem_req}, 32'h0);
    check("t3_pc_hold",  pc,                32'h0);
    instr_ready = 1'b1;
    tick();
    check("t3_pc_next",  pc,                32'h4);
    check("t3_req_full", {31'h0, imem_req}, 32'h0);
    tick();
    check("t3_empty",  {31'h0, instr_valid}, 32'h0);
    check("t3_req8",   {31'h0, imem_req},    32'h1);
    check("t3_addr8",  imem_addr,            32'h8);

    // Test 4: redirect with request outstanding, late ack squashed.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    check("t4_req_held",  {31'h0, imem_req}, 32'h1);
    check("t4_addr_held", imem_addr,         32'h8);
    tick();
    check("t4_addr_held2", imem_addr, 32'h8);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("t4_new_addr", imem_addr,            32'h100);
    check("t4_new_req",  {31'h0, imem_req},    32'h1);
    check("t4_valid",    {31'h0, instr_valid}, 32'h0);
    check("t4_instr",    instr,                32'h0000_0013);
    tick();
    check("t4_no_word", {31'h0, instr_valid}, 32'h0);
    check("t4_addr",    imem_addr,            32'h100);

    // Test 5: redirect in the same cycle as ack.
    imem_ack    = 1'b1;
    imem_rdata  = 32'h1111_1111;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    check("t5_addr",  imem_addr,            32'h200);
    check("t5_req",   {31'h0, imem_req},    32'h1);
    check("t5_valid", {31'h0, instr_valid}, 32'h0);
    check("t5_flush", {31'h0, flush},       32'h1);
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rdata  = 32'h0050_0293;
    tick();
    check("t5_pc",    pc,        32'h200);
    check("t5_instr", instr,     32'h0050_0293);
    check("t5_next",  imem_addr, 32'h204);
    idle_inputs();

    // Test 6: reset during WAIT, ack arriving while and after reset.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_BABE;
    tick();
    tick();
    check_reset_outputs("t6_held");
    rst_n = 1'b1;
    tick();
    idle_inputs();
    check("t6_req",   {31'h0, imem_req},    32'h1);
    check("t6_addr",  imem_addr,            32'h0);
    check("t6_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    check("t6_valid2", {31'h0, instr_valid}, 32'h0);
    check("t6_instr",  instr,                32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
